// File: rtl/mem_rd_arbiter.sv
// Two-client (I-cache / D-cache) refill read arbiter in front of a single
// memory read port. One burst is in flight at a time; ties are broken
// round robin against the client that owned the previous burst.
module mem_rd_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache
  input  logic              from_icache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_icache_rd_req_addr,
  output logic              to_icache_rd_req_ready,
  output logic              to_icache_rd_rsp_valid,
  input  logic              from_icache_rd_rsp_ready,
  // D-cache
  input  logic              from_dcache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dcache_rd_req_addr,
  output logic              to_dcache_rd_req_ready,
  output logic              to_dcache_rd_rsp_valid,
  input  logic              from_dcache_rd_rsp_ready,
  // Shared response payload
  output logic [31:0]       to_cache_rd_rsp_data,
  output logic              to_cache_rd_rsp_last,
  // Memory
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [31:0]       from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              win;
  logic              any_req;
  logic              beat_hs;

  // Pick the winner among current requesters; a tie goes to the client that
  // did not own the previous burst.
  always_comb begin
    win = IC;
    if (from_icache_rd_req_valid && from_dcache_rd_req_valid)
      win = ~last_grant;
    else if (from_dcache_rd_req_valid)
      win = DC;
  end

  assign any_req = from_icache_rd_req_valid | from_dcache_rd_req_valid;
  assign beat_hs = (state == DATA) && from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;

  // Burst sequencing: latch owner/address in IDLE, hold in ADDR until memory
  // accepts, stream beats in DATA until the memory marks the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= IC;
      last_grant <= DC;
      addr_q     <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner  <= win;
          addr_q <= (win == DC) ? from_dcache_rd_req_addr : from_icache_rd_req_addr;
          state  <= ADDR;
        end
        ADDR: if (from_mem_rd_req_ready) state <= DATA;
        DATA: if (beat_hs && from_mem_rd_rsp_last) begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request channel: only the latched request is presented, client inputs
  // are ignored once ADDR is entered.
  assign to_mem_rd_req_valid    = (state == ADDR);
  assign to_mem_rd_req_addr     = addr_q;
  assign to_icache_rd_req_ready = (state == ADDR) && from_mem_rd_req_ready && (owner == IC);
  assign to_dcache_rd_req_ready = (state == ADDR) && from_mem_rd_req_ready && (owner == DC);

  // Response channel: routed to the owner only while in DATA; payload is
  // broadcast unconditionally and qualified by the per-client valid.
  assign to_icache_rd_rsp_valid = (state == DATA) && from_mem_rd_rsp_valid && (owner == IC);
  assign to_dcache_rd_rsp_valid = (state == DATA) && from_mem_rd_rsp_valid && (owner == DC);
  assign to_mem_rd_rsp_ready    = (state == DATA) &&
                                  ((owner == DC) ? from_dcache_rd_rsp_ready
                                                 : from_icache_rd_rsp_ready);
  assign to_cache_rd_rsp_data   = from_mem_rd_rsp_data;
  assign to_cache_rd_rsp_last   = from_mem_rd_rsp_last;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: reset state, arbitration order,
// address back-pressure, response back-pressure, mid-burst reset and
// stray-beat suppression.
module tb_mem_rd_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_req_valid, dc_req_valid;
  logic [ADDR_W-1:0] ic_req_addr, dc_req_addr;
  logic              ic_req_ready, dc_req_ready;
  logic              ic_rsp_valid, dc_rsp_valid;
  logic              ic_rsp_ready, dc_rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              mem_rsp_last;
  logic              mem_rsp_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_icache_rd_req_valid (ic_req_valid),
    .from_icache_rd_req_addr  (ic_req_addr),
    .to_icache_rd_req_ready   (ic_req_ready),
    .to_icache_rd_rsp_valid   (ic_rsp_valid),
    .from_icache_rd_rsp_ready (ic_rsp_ready),
    .from_dcache_rd_req_valid (dc_req_valid),
    .from_dcache_rd_req_addr  (dc_req_addr),
    .to_dcache_rd_req_ready   (dc_req_ready),
    .to_dcache_rd_rsp_valid   (dc_rsp_valid),
    .from_dcache_rd_rsp_ready (dc_rsp_ready),
    .to_cache_rd_rsp_data     (rsp_data),
    .to_cache_rd_rsp_last     (rsp_last),
    .to_mem_rd_req_valid      (mem_req_valid),
    .to_mem_rd_req_addr       (mem_req_addr),
    .from_mem_rd_req_ready    (mem_req_ready),
    .from_mem_rd_rsp_valid    (mem_rsp_valid),
    .from_mem_rd_rsp_data     (mem_rsp_data),
    .from_mem_rd_rsp_last     (mem_rsp_last),
    .to_mem_rd_rsp_ready      (mem_rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All valid/ready outputs packed for one-shot comparison.
  function automatic logic [31:0] vr_outs();
    return {25'd0, mem_req_valid, ic_req_ready, dc_req_ready,
            ic_rsp_valid, dc_rsp_valid, mem_rsp_ready, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. own: 0 = icache expected to win, 1 = dcache.
  // addr_stall: cycles with memory req_ready low before acceptance.
  // stall_beat/stall_len: owner rsp_ready dropped before that beat.
  task automatic run_req(input string nm, input logic ic, input logic dc,
                         input logic [31:0] ia, input logic [31:0] da, input logic own,
                         input int addr_stall, input int beats,
                         input int stall_beat, input int stall_len);
    logic [31:0] exp_addr;
    int          nbeat;
    exp_addr = own ? da : ia;
    nbeat    = 0;
    // IDLE cycle: present the request(s)
    ic_req_valid = ic; ic_req_addr = ia;
    dc_req_valid = dc; dc_req_addr = da;
    #1;
    chk({nm, " idle req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    step();
    // ADDR: withdraw client requests, the latched one must still be issued
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    ic_req_addr = 32'hDEAD_0000; dc_req_addr = 32'hBEEF_0000;
    for (int k = 0; k <= addr_stall; k++) begin
      mem_req_ready = (k == addr_stall);
      #1;
      chk({nm, " mem_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
      chk({nm, " mem_req_addr"}, mem_req_addr, exp_addr);
      chk({nm, " ic_req_ready"}, {31'd0, ic_req_ready}, {31'd0, (k == addr_stall) && !own});
      chk({nm, " dc_req_ready"}, {31'd0, dc_req_ready}, {31'd0, (k == addr_stall) && own});
      step();
    end
    mem_req_ready = 1'b0;
    // DATA
    ic_rsp_ready = 1'b1; dc_rsp_ready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          ic_rsp_ready = own; dc_rsp_ready = !own;
          mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000 + b; mem_rsp_last = (b == beats - 1);
          #1;
          chk({nm, " stall mem_rsp_ready"}, {31'd0, mem_rsp_ready}, 32'd0);
          chk({nm, " stall req_valid"}, {31'd0, mem_req_valid}, 32'd0);
          step();
        end
        ic_rsp_ready = 1'b1; dc_rsp_ready = 1'b1;
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000 + b; mem_rsp_last = (b == beats - 1);
      #1;
      chk({nm, " ic_rsp_valid"}, {31'd0, ic_rsp_valid}, {31'd0, !own});
      chk({nm, " dc_rsp_valid"}, {31'd0, dc_rsp_valid}, {31'd0, own});
      chk({nm, " mem_rsp_ready"}, {31'd0, mem_rsp_ready}, 32'd1);
      chk({nm, " rsp_data"}, rsp_data, 32'hA000 + b);
      if (mem_rsp_ready && (own ? dc_rsp_valid : ic_rsp_valid)) nbeat++;
      step();
    end
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    #1;
    chk({nm, " beats delivered"}, nbeat, beats);
    chk({nm, " back to idle"}, vr_outs(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ic_req_valid = 0; dc_req_valid = 0; ic_req_addr = 0; dc_req_addr = 0;
    ic_rsp_ready = 0; dc_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_last = 0;
    #2;
    chk("reset outputs", vr_outs(), 32'd0);
    chk("reset addr", mem_req_addr, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Stray beats in IDLE must not be forwarded
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555; ic_rsp_ready = 1; dc_rsp_ready = 1;
    #1;
    chk("idle stray outputs", vr_outs(), 32'd0);
    chk("idle data passthru", rsp_data, 32'h5555);
    step();
    mem_rsp_valid = 1'b0;
    chk("idle stray stays idle", vr_outs(), 32'd0);

    // Round robin ties: icache, dcache, icache
    run_req("tie1", 1, 1, 32'h0000_0100, 32'h0000_0200, 1'b0, 0, 2, -1, 0);
    run_req("tie2", 1, 1, 32'h0000_0120, 32'h0000_0220, 1'b1, 0, 2, -1, 0);
    run_req("tie3", 1, 1, 32'h0000_0140, 32'h0000_0240, 1'b0, 0, 2, -1, 0);

    // Icache-only 8-beat refill
    run_req("ic8", 1, 0, 32'h0000_1000, 32'h0, 1'b0, 0, 8, -1, 0);
    // Memory address back-pressure for 3 cycles
    run_req("astall", 0, 1, 32'h0, 32'h0000_2040, 1'b1, 3, 4, -1, 0);
    // Owner response back-pressure for 2 cycles at beat 3
    run_req("rstall", 1, 0, 32'h0000_3060, 32'h0, 1'b0, 0, 8, 3, 2);

    // Reset during beat 4 of a dcache burst
    dc_req_valid = 1; dc_req_addr = 32'h0000_4080; mem_req_ready = 1;
    step();
    dc_req_valid = 0;
    step();
    mem_req_ready = 0; dc_rsp_ready = 1;
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid = 1; mem_rsp_data = b; mem_rsp_last = 0;
      step();
    end
    mem_rsp_valid = 1; mem_rsp_data = 4;
    #1;
    chk("pre-rst dc_rsp_valid", {31'd0, dc_rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-burst rst outputs", vr_outs(), 32'd0);
    mem_rsp_valid = 0;
    step();
    rst = 1'b0;
    step();
    chk("post-rst idle", vr_outs(), 32'd0);
    run_req("postrst", 1, 0, 32'h0000_5000, 32'h0, 1'b0, 0, 3, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
